// File: rtl/multdiv_pkg.sv
// Shared constants and types for the iterative signed multiply/divide unit.
package multdiv_pkg;

    localparam int OP_W           = 32;
    localparam int DEF_ITERATIONS = 32;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    typedef enum logic {
        OP_MUL,
        OP_DIV
    } op_t;

    // Everything about an operation that is frozen at the start pulse.
    typedef struct packed {
        op_t             op;
        logic            neg;
        logic            b_zero;
        logic            div_ovf;
        logic [OP_W-1:0] opnd;
    } req_t;

    function automatic logic [OP_W-1:0] mag(input logic [OP_W-1:0] v);
        return v[OP_W-1] ? -v : v;
    endfunction

endpackage

// File: rtl/multdiv_step.sv
// One radix-2 iteration on the {hi,lo} working register: shift-and-add for
// multiply, restoring shift-subtract for divide. Purely combinational.
module multdiv_step
    import multdiv_pkg::*;
(
    input  op_t             op,
    input  logic [OP_W-1:0] opnd,
    input  logic [OP_W-1:0] hi,
    input  logic [OP_W-1:0] lo,
    output logic [OP_W-1:0] hi_nxt,
    output logic [OP_W-1:0] lo_nxt
);

    logic [OP_W:0]   sum;
    logic [OP_W:0]   diff;
    logic [OP_W-1:0] shifted;

    // The partial remainder is always below a divisor magnitude of at most
    // 2^31, so the shifted remainder still fits in OP_W bits.
    always_comb begin
        shifted = {hi[OP_W-2:0], lo[OP_W-1]};
        sum     = {1'b0, hi} + {1'b0, (lo[0] ? opnd : {OP_W{1'b0}})};
        diff    = {1'b0, shifted} - {1'b0, opnd};
        hi_nxt  = sum[OP_W:1];
        lo_nxt  = {sum[0], lo[OP_W-1:1]};
        if (op == OP_DIV) begin
            if (diff[OP_W]) begin
                hi_nxt = shifted;
                lo_nxt = {lo[OP_W-2:0], 1'b0};
            end else begin
                hi_nxt = diff[OP_W-1:0];
                lo_nxt = {lo[OP_W-2:0], 1'b1};
            end
        end
    end

endmodule

// File: rtl/multdiv_unit.sv
// Iterative 32-bit signed multiply / divide: one radix-2 step per cycle on
// operand magnitudes, sign fixed up when the result is latched.
module multdiv_unit
    import multdiv_pkg::*;
#(
    parameter int ITERATIONS = DEF_ITERATIONS
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            ctrl_MULT,
    input  logic            ctrl_DIV,
    input  logic [OP_W-1:0] data_operandA,
    input  logic [OP_W-1:0] data_operandB,
    output logic [OP_W-1:0] data_result,
    output logic            data_exception,
    output logic            data_resultRDY
);

    localparam int CNT_W = $clog2(ITERATIONS);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    req_t              req;
    req_t              req_in;
    logic [OP_W-1:0]   hi;
    logic [OP_W-1:0]   lo;
    logic [OP_W-1:0]   hi_nxt;
    logic [OP_W-1:0]   lo_nxt;
    logic [OP_W-1:0]   a_mag;
    logic [OP_W-1:0]   b_mag;
    logic [OP_W-1:0]   lo_init;
    logic              start;
    logic [2*OP_W-1:0] prod;
    logic [2*OP_W-1:0] sprod;
    logic [OP_W-1:0]   fin_res;
    logic              fin_exc;

    assign start = ctrl_MULT | ctrl_DIV;

    always_comb begin
        a_mag          = mag(data_operandA);
        b_mag          = mag(data_operandB);
        req_in.op      = ctrl_MULT ? OP_MUL : OP_DIV;
        req_in.neg     = data_operandA[OP_W-1] ^ data_operandB[OP_W-1];
        req_in.b_zero  = (data_operandB == '0);
        req_in.div_ovf = (data_operandA == {1'b1, {(OP_W-1){1'b0}}}) &&
                         (data_operandB == '1);
        req_in.opnd    = ctrl_MULT ? a_mag : b_mag;
        lo_init        = ctrl_MULT ? b_mag : a_mag;
    end

    multdiv_step u_step (
        .op     (req.op),
        .opnd   (req.opnd),
        .hi     (hi),
        .lo     (lo),
        .hi_nxt (hi_nxt),
        .lo_nxt (lo_nxt)
    );

    // Negating {remainder, quotient} as a whole still yields -quotient in the
    // low word, so one signed fix-up serves both operations.
    always_comb begin
        prod  = {hi_nxt, lo_nxt};
        sprod = req.neg ? -prod : prod;
        fin_res = sprod[OP_W-1:0];
        fin_exc = 1'b0;
        if (req.op == OP_MUL) begin
            fin_exc = !((&sprod[2*OP_W-1:OP_W-1]) || !(|sprod[2*OP_W-1:OP_W-1]));
        end else if (req.b_zero) begin
            fin_res = '0;
            fin_exc = 1'b1;
        end else if (req.div_ovf) begin
            fin_res = {1'b1, {(OP_W-1){1'b0}}};
            fin_exc = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= S_IDLE;
            cnt            <= '0;
            req            <= '0;
            hi             <= '0;
            lo             <= '0;
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
        end else begin
            data_resultRDY <= 1'b0;
            if (start) begin
                // Also the abort path when already busy.
                req   <= req_in;
                cnt   <= '0;
                hi    <= '0;
                lo    <= lo_init;
                state <= S_RUN;
            end else begin
                case (state)
                    S_RUN: begin
                        hi <= hi_nxt;
                        lo <= lo_nxt;
                        if (cnt == CNT_W'(ITERATIONS - 1)) begin
                            state          <= S_DONE;
                            data_result    <= fin_res;
                            data_exception <= fin_exc;
                            data_resultRDY <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    S_DONE:  state <= S_IDLE;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/multdiv_unit.md
MULTDIV_UNIT -- requirements
Module: multdiv_unit

Interface
REQ-001 SHALL expose parameter ITERATIONS, default 32: number of compute cycles per operation; fixed at 32 for the 32-bit datapath.
REQ-002 SHALL expose port clock, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-003 SHALL expose port reset, input, 1, synchronous and active-high.
REQ-004 SHALL expose port ctrl_MULT, input, 1, a one-cycle start pulse for signed multiply.
REQ-005 SHALL expose port ctrl_DIV, input, 1, a one-cycle start pulse for signed divide.
REQ-006 SHALL expose port data_operandA, input, 32: multiplicand or dividend, two's complement.
REQ-007 SHALL expose port data_operandB, input, 32: multiplier or divisor, two's complement.
REQ-008 SHALL expose port data_result, output, 32: the low product word or the quotient.
REQ-009 SHALL expose port data_exception, output, 1: overflow, divide-by-zero or divide overflow.
REQ-010 SHALL expose port data_resultRDY, output, 1: result-valid strobe.

Function
REQ-011 SHALL implement states IDLE, RUN and DONE.
REQ-012 SHALL, when a start pulse is seen on edge E0: latch both operands and the operation type, clear the counter, and go to RUN.
REQ-013 SHALL perform one radix-2 iteration per edge in RUN: shift-and-add for multiply, restoring shift-subtract for divide.
REQ-014 SHALL run the iterations on edges E1..E32 and move to DONE on E32, when the counter equals ITERATIONS-1.
REQ-015 SHALL drive data_resultRDY=1 only in DONE: exactly one cycle, between E32 and E33. DONE SHALL return to IDLE on E33.
REQ-016 SHALL latch data_result and data_exception on entry to DONE and hold them until the next start or reset.
REQ-017 SHALL, for multiply, compute the full 64-bit signed product internally and output its low 32 bits. data_exception=1 iff the upper 33 bits are not all equal.
REQ-018 SHALL, for divide, operate on operand magnitudes, truncate toward zero and give the quotient the sign of A XOR B. The remainder SHALL be discarded.
REQ-019 SHALL, when the divisor is 0: output data_result=0 and data_exception=1, with the normal 32-cycle latency.
REQ-020 SHALL, for 0x80000000 / 0xFFFFFFFF: output data_result=0x80000000 and data_exception=1.
REQ-021 SHALL give ctrl_MULT priority when ctrl_MULT and ctrl_DIV are high on the same edge.
REQ-022 SHALL treat a start pulse in RUN or DONE as abort-and-restart: re-latch the operands and restart at E0. No data_resultRDY SHALL be emitted for the aborted operation.
REQ-023 SHALL ignore operand changes after E0.

Reset
REQ-024 SHALL, when reset=1 on an edge: set the state to IDLE, the counter to 0, and data_result, data_exception and data_resultRDY to 0, regardless of state.
REQ-025 SHALL give reset priority over simultaneous ctrl_MULT/ctrl_DIV; a start pulse coincident with reset SHALL be dropped.

Structure
REQ-026 SHALL place the state encoding, ITERATIONS and the operand width constant (32) in shared package multdiv_pkg.
REQ-027 SHALL isolate the per-iteration add/subtract-and-shift datapath in one sub-module, multdiv_step. The FSM and counter SHALL remain in multdiv_unit.

Verification
REQ-028 SHALL test ctrl_MULT, A=7, B=-6: data_result=0xFFFFFFD6, data_exception=0, data_resultRDY high only in the cycle after E32.
REQ-029 SHALL test ctrl_MULT, A=B=0x00010000: data_result=0x00000000, data_exception=1.
REQ-030 SHALL test ctrl_DIV, A=-7, B=2: data_result=0xFFFFFFFD, data_exception=0. It SHALL also test A=5, B=0: data_result=0, data_exception=1.
REQ-031 SHALL test ctrl_MULT 3*4 at E0, then ctrl_DIV 100/7 at E10: one data_resultRDY only, after E42, with data_result=14.
REQ-032 SHALL test ctrl_DIV at E0 with reset at E5: no data_resultRDY through E40, and all outputs 0.
REQ-033 SHALL test ctrl_MULT and ctrl_DIV together, A=6, B=3: data_result=18 (multiply taken).
